// File: rtl/spi_regmap_burst.sv
// SPI mode-0 slave register map with writable config registers, read-only
// status registers and auto-increment burst transfers. All SPI pins are
// oversampled in the clk domain through 2-flop synchronisers.
module spi_regmap_burst #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_CFG  = 8,
    parameter int NUM_STAT = 4,
    parameter logic [NUM_CFG*DATA_W-1:0] CFG_RESET = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_sck,
    input  logic                         spi_sdi,
    input  logic                         spi_cs_n,
    output logic                         spi_sdo,
    output logic                         spi_sdo_oe,
    output logic [NUM_CFG*DATA_W-1:0]    cfg_o,
    output logic [NUM_CFG-1:0]           cfg_wr_o,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_i
);

    // Bit counter must reach the larger of the last CMD index and last DATA index
    localparam int CNT_MAX = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W:0]    cmd_sr;
    logic [DATA_W-1:0]  data_sr;
    logic [ADDR_W-1:0]  addr;
    logic               inst;
    logic [DATA_W-1:0]  sdo_sr;

    logic sck_meta, sck_sync, sck_prev;
    logic sdi_meta, sdi_sync;
    logic cs_meta, cs_sync, cs_prev;

    logic               sck_rise;
    logic               sck_fall;
    logic               cs_fall;
    logic [ADDR_W:0]    cmd_next;
    logic [DATA_W-1:0]  data_next;
    logic [ADDR_W-1:0]  snap_addr;
    logic [DATA_W-1:0]  rd_val;

    // Bring the asynchronous SPI pins into the clk domain and keep one history flop for edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
            cs_meta  <= 1'b1;
            cs_sync  <= 1'b1;
            cs_prev  <= 1'b1;
        end else begin
            sck_meta <= spi_sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            sdi_meta <= spi_sdi;
            sdi_sync <= sdi_meta;
            cs_meta  <= spi_cs_n;
            cs_sync  <= cs_meta;
            cs_prev  <= cs_sync;
        end
    end

    assign sck_rise  = sck_sync & ~sck_prev;
    assign sck_fall  = ~sck_sync & sck_prev;
    assign cs_fall   = ~cs_sync & cs_prev;
    assign cmd_next  = {cmd_sr[ADDR_W-1:0], sdi_sync};
    assign data_next = {data_sr[DATA_W-2:0], sdi_sync};
    // Snapshot target: freshly shifted address at end of CMD, next burst address in DATA
    assign snap_addr = (state == ST_CMD) ? cmd_next[ADDR_W-1:0] : (addr + ADDR_W'(1));

    // Read-back mux: config register, status register, or zero when unmapped
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (snap_addr == ADDR_W'(i)) begin
                rd_val = cfg_o[i*DATA_W +: DATA_W];
            end else begin
                rd_val = rd_val;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (snap_addr == ADDR_W'(NUM_CFG + j)) begin
                rd_val = stat_i[j*DATA_W +: DATA_W];
            end else begin
                rd_val = rd_val;
            end
        end
    end

    // Frame FSM: shifts command and data, commits writes, loads and shifts read snapshots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            data_sr    <= '0;
            addr       <= '0;
            inst       <= 1'b0;
            sdo_sr     <= '0;
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
            cfg_o      <= CFG_RESET;
            cfg_wr_o   <= '0;
        end else begin
            cfg_wr_o   <= '0;
            spi_sdo_oe <= ~cs_sync;
            if (cs_sync) begin
                // Deselect wins over any same-cycle sck edge; a partial field is dropped
                state   <= ST_IDLE;
                bit_cnt <= '0;
                sdo_sr  <= '0;
                spi_sdo <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            cmd_sr  <= '0;
                            spi_sdo <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr <= cmd_next;
                            if (bit_cnt == CNT_W'(ADDR_W)) begin
                                inst    <= cmd_next[ADDR_W];
                                addr    <= cmd_next[ADDR_W-1:0];
                                sdo_sr  <= cmd_next[ADDR_W] ? rd_val : '0;
                                data_sr <= '0;
                                bit_cnt <= '0;
                                state   <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sck_fall) begin
                            spi_sdo <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            data_sr <= data_next;
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                bit_cnt <= '0;
                                addr    <= addr + ADDR_W'(1);
                                sdo_sr  <= inst ? rd_val : '0;
                                if (!inst) begin
                                    for (int i = 0; i < NUM_CFG; i++) begin
                                        if (addr == ADDR_W'(i)) begin
                                            cfg_o[i*DATA_W +: DATA_W] <= data_next;
                                            cfg_wr_o[i]               <= 1'b1;
                                        end
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sck_fall) begin
                            spi_sdo <= sdo_sr[DATA_W-1];
                            sdo_sr  <= {sdo_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_regmap_burst.sv
// Scoreboard bench for spi_regmap_burst: an SPI master task drives frames,
// expectations come from an array-based register model, and a monitor
// compares write strobes and read-back bytes as they appear.
module tb_spi_regmap_burst;

    localparam logic [63:0] CFG_RST = 64'h0000_0000_0000_00A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sck;
    logic        spi_sdi;
    logic        spi_cs_n;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic [63:0] cfg_o;
    logic [7:0]  cfg_wr_o;
    logic [31:0] stat_i;

    spi_regmap_burst #(
        .ADDR_W(7), .DATA_W(8), .NUM_CFG(8), .NUM_STAT(4), .CFG_RESET(CFG_RST)
    ) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_cs_n(spi_cs_n), .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .cfg_o(cfg_o), .cfg_wr_o(cfg_wr_o), .stat_i(stat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } wr_t;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_cfg [8];
    logic [7:0] model_stat [4];
    logic [7:0] tx_buf [8];
    wr_t        exp_wr [$];
    logic [7:0] exp_rd [$];
    logic [7:0] rx_q [$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] model_read(logic [6:0] a);
        if (a < 7'd8)       return model_cfg[a[2:0]];
        else if (a < 7'd12) return model_stat[a[1:0]];
        else                return 8'h00;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) model_cfg[k] = CFG_RST[k*8 +: 8];
    endfunction

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = model_cfg[k];
        return v;
    endfunction

    task automatic set_stat(input logic [31:0] v);
        stat_i = v;
        for (int k = 0; k < 4; k++) model_stat[k] = v[k*8 +: 8];
    endtask

    // SPI master: sends stop_bits bits (all when negative), optionally pulses rst at rst_bit
    task automatic spi_xfer(input bit inst, input logic [6:0] a, input int nfields,
                            input int stop_bits, input int rst_bit);
        int         nbits;
        logic [7:0] rx;
        logic [7:0] byte_v;
        logic       bitv;
        nbits = (stop_bits < 0) ? 8 + 8 * nfields : stop_bits;
        rx = 8'h00;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (b == 0)            bitv = inst;
            else if (b < 8)        bitv = a[7 - b];
            else begin
                byte_v = tx_buf[(b - 8) / 8];
                bitv   = byte_v[7 - ((b - 8) % 8)];
            end
            spi_sdi = bitv;
            repeat (5) @(negedge clk);
            if (b == 0) check("sdo_oe_in_frame", spi_sdo_oe, 1'b1);
            if (b == 4) check("sdo_zero_in_cmd", spi_sdo, 1'b0);
            if (inst && b >= 8) rx = {rx[6:0], spi_sdo};
            spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_sck = 1'b0;
            if (inst && b >= 8 && ((b - 8) % 8) == 7) rx_q.push_back(rx);
        end
        repeat (5) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Push model expectations for every field that completes, then drive the frame
    task automatic do_frame(input bit inst, input logic [6:0] a, input int nfields,
                            input int stop_bits);
        int         done;
        logic [6:0] fa;
        if (stop_bits < 0)      done = nfields;
        else if (stop_bits < 8) done = 0;
        else                    done = (stop_bits - 8) / 8;
        for (int k = 0; k < done; k++) begin
            fa = a + 7'(k);
            if (inst) begin
                exp_rd.push_back(model_read(fa));
            end else if (fa < 7'd8) begin
                model_cfg[fa[2:0]] = tx_buf[k];
                exp_wr.push_back('{idx: int'(fa), val: tx_buf[k]});
            end
        end
        spi_xfer(inst, a, nfields, stop_bits, -1);
    endtask

    // Monitor: compare each strobe and each received byte against the scoreboard queues
    initial begin
        wr_t        w;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (!rst && cfg_wr_o != 8'h00) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_strobe", cfg_wr_o, 8'h00);
                end else begin
                    w = exp_wr.pop_front();
                    check("strobe_onehot", cfg_wr_o, 8'd1 << w.idx);
                    check("write_value", cfg_o[w.idx*8 +: 8], w.val);
                end
            end
            while (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                if (exp_rd.size() == 0) check("unexpected_read", r, 8'hxx);
                else                    check("read_data", r, exp_rd.pop_front());
            end
        end
    end

    initial begin
        int         nf;
        int         stop;
        int         pick;
        bit         rinst;
        logic [6:0] ra;
        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_sdi  = 1'b0;
        set_stat(32'hFFFF_0000);
        model_reset();
        repeat (4) @(negedge clk);
        check("reset_cfg", cfg_o, CFG_RST);
        check("reset_oe", spi_sdo_oe, 1'b0);
        check("reset_sdo", spi_sdo, 1'b0);
        check("reset_strobe", cfg_wr_o, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // reset value readback
        do_frame(1'b1, 7'd0, 1, -1);

        // single write and readback
        tx_buf[0] = 8'h3C;
        do_frame(1'b0, 7'd7, 1, -1);
        do_frame(1'b1, 7'd7, 1, -1);
        check("cfg_after_write", cfg_o, model_vec());

        // status and unmapped reads, ignored status write
        do_frame(1'b1, 7'd8, 1, -1);
        do_frame(1'b1, 7'd11, 1, -1);
        do_frame(1'b1, 7'd12, 1, -1);
        tx_buf[0] = 8'h55;
        do_frame(1'b0, 7'd9, 1, -1);
        do_frame(1'b1, 7'd9, 1, -1);
        check("cfg_after_stat_write", cfg_o, model_vec());

        // burst write running past the last config register
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33; tx_buf[3] = 8'h44;
        do_frame(1'b0, 7'd5, 4, -1);
        check("cfg_after_burst", cfg_o, model_vec());
        do_frame(1'b1, 7'd5, 3, -1);

        // abort after four data bits, then a full write
        tx_buf[0] = 8'h99;
        do_frame(1'b0, 7'd2, 1, 12);
        check("cfg_after_abort", cfg_o, model_vec());
        tx_buf[0] = 8'h80;
        do_frame(1'b0, 7'd2, 1, -1);
        check("cfg_after_abort_retry", cfg_o, model_vec());

        // reset during CMD of a write to reg1
        tx_buf[0] = 8'h77;
        do_frame(1'b0, 7'd1, 1, -1);
        model_reset();
        tx_buf[0] = 8'h04;
        spi_xfer(1'b0, 7'd1, 1, -1, 3);
        check("cfg_after_midframe_rst", cfg_o, model_vec());
        do_frame(1'b0, 7'd1, 1, -1);
        check("cfg_after_rst_rewrite", cfg_o, model_vec());

        // randomized frames, including wrap at the top of the address space
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) set_stat($urandom);
            rinst = 1'($urandom_range(0, 1));
            pick  = $urandom_range(0, 17);
            ra    = (pick < 16) ? 7'(pick) : ((pick == 16) ? 7'd126 : 7'd127);
            nf    = $urandom_range(1, 3);
            for (int k = 0; k < 8; k++) tx_buf[k] = 8'($urandom);
            stop  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8 + 8 * nf - 1) : -1;
            do_frame(rinst, ra, nf, stop);
            check("cfg_random", cfg_o, model_vec());
        end

        repeat (20) @(negedge clk);
        check("writes_drained", exp_wr.size(), 0);
        check("reads_drained", exp_rd.size(), 0);
        check("rx_drained", rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
